// File: rtl/jbus_pkg.sv
// Shared types and helpers for the jbus register-transfer sequencer.
// Holds the FSM state encoding, the phase-counter width and the index check.
package jbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN,
    SET,
    HOLD,
    DONE
  } jbus_state_e;

  localparam int PHASE_W = 4;

  // A transfer is legal only between two distinct registers that exist on the bus.
  function automatic logic idx_ok(input int src, input int dst, input int nregs);
    return (src != dst) && (src < nregs) && (dst < nregs);
  endfunction

endpackage

// File: rtl/jbus_ctrl_if.sv
// Bundle of the requester handshake and register-bank strobe signals of jbus_ctrl.
// The master side is the requesters/bank, the slave side is the controller.
interface jbus_ctrl_if #(
  parameter int NREGS = 4
);
  localparam int IDXW = $clog2(NREGS);

  logic             wreq0;
  logic [IDXW-1:0]  bsrc0;
  logic [IDXW-1:0]  bdst0;
  logic             wreq1;
  logic [IDXW-1:0]  bsrc1;
  logic [IDXW-1:0]  bdst1;
  logic             wack0;
  logic             wack1;
  logic             werr;
  logic [NREGS-1:0] bwe;
  logic [NREGS-1:0] bws;
  logic             wbusy;
  logic             wgnt;

  modport master (
    output wreq0, bsrc0, bdst0, wreq1, bsrc1, bdst1,
    input  wack0, wack1, werr, bwe, bws, wbusy, wgnt
  );

  modport slave (
    input  wreq0, bsrc0, bdst0, wreq1, bsrc1, bdst1,
    output wack0, wack1, werr, bwe, bws, wbusy, wgnt
  );

endinterface

// File: rtl/jrr_arb2.sv
// Two-input round-robin arbiter; on contention the requester that did not win
// last time is chosen. The last-grant pointer is owned by the caller.
module jrr_arb2 (
  input  logic wreq0,
  input  logic wreq1,
  input  logic last_gnt,
  output logic wvalid,
  output logic wgnt
);

  always_comb begin
    wvalid = wreq0 | wreq1;
    wgnt   = (wreq0 & wreq1) ? ~last_gnt : wreq1;
  end

endmodule

// File: rtl/jbus_ctrl.sv
// Round-robin sequencer that copies one bus register into another by driving
// the enable/set strobe sequence the latch-based register bank needs.
module jbus_ctrl
  import jbus_pkg::*;
#(
  parameter int NREGS     = 4,
  parameter int SETUP_CYC = 1,
  parameter int SET_CYC   = 2
) (
  input  logic     wclk,
  input  logic     wrst_n,
  jbus_ctrl_if.slave bus
);

  localparam int IDXW = $clog2(NREGS);
  localparam logic [PHASE_W-1:0] SETUP_LD = PHASE_W'(SETUP_CYC - 1);
  localparam logic [PHASE_W-1:0] SET_LD   = PHASE_W'(SET_CYC - 1);

  jbus_state_e        state_q, state_d;
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic [NREGS-1:0]   bwe_q, bwe_d;
  logic [NREGS-1:0]   bws_q, bws_d;
  logic               wack0_q, wack0_d;
  logic               wack1_q, wack1_d;
  logic               werr_q, werr_d;
  logic               wbusy_q, wbusy_d;
  logic               gnt_q, gnt_d;
  logic [IDXW-1:0]    src_q, src_d;
  logic [IDXW-1:0]    dst_q, dst_d;
  logic [IDXW-1:0]    src_sel, dst_sel;
  logic               arb_valid, arb_gnt;

  function automatic logic [NREGS-1:0] onehot(input logic [IDXW-1:0] i);
    return {{(NREGS-1){1'b0}}, 1'b1} << i;
  endfunction

  jrr_arb2 u_arb (
    .wreq0    (bus.wreq0),
    .wreq1    (bus.wreq1),
    .last_gnt (gnt_q),
    .wvalid   (arb_valid),
    .wgnt     (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    bwe_d   = bwe_q;
    bws_d   = bws_q;
    wack0_d = 1'b0;
    wack1_d = 1'b0;
    werr_d  = 1'b0;
    gnt_d   = gnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    src_sel = arb_gnt ? bus.bsrc1 : bus.bsrc0;
    dst_sel = arb_gnt ? bus.bdst1 : bus.bdst0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d = arb_gnt;
          src_d = src_sel;
          dst_d = dst_sel;
          if (idx_ok(int'(src_sel), int'(dst_sel), NREGS)) begin
            state_d = EN;
            cnt_d   = SETUP_LD;
            bwe_d   = onehot(src_sel);
          end else begin
            // Rejected transfers skip straight to the ack without touching any strobe.
            state_d = DONE;
            wack0_d = ~arb_gnt;
            wack1_d = arb_gnt;
            werr_d  = 1'b1;
          end
        end
      end
      EN: begin
        if (cnt_q == '0) begin
          state_d = SET;
          cnt_d   = SET_LD;
          bws_d   = onehot(dst_q);
        end
      end
      SET: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          bws_d   = '0;
        end
      end
      HOLD: begin
        // Source stays enabled one extra cycle so the bus is stable as set falls.
        state_d = DONE;
        bwe_d   = '0;
        wack0_d = ~gnt_q;
        wack1_d = gnt_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        bwe_d   = '0;
        bws_d   = '0;
      end
    endcase

    wbusy_d = (state_d != IDLE);
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bwe_q   <= '0;
      bws_q   <= '0;
      wack0_q <= 1'b0;
      wack1_q <= 1'b0;
      werr_q  <= 1'b0;
      wbusy_q <= 1'b0;
      gnt_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bwe_q   <= bwe_d;
      bws_q   <= bws_d;
      wack0_q <= wack0_d;
      wack1_q <= wack1_d;
      werr_q  <= werr_d;
      wbusy_q <= wbusy_d;
      gnt_q   <= gnt_d;
    end
  end

  // Latched transfer indices are data only; they are always rewritten on a grant.
  always_ff @(posedge wclk) begin
    src_q <= src_d;
    dst_q <= dst_d;
  end

  assign bus.bwe   = bwe_q;
  assign bus.bws   = bws_q;
  assign bus.wack0 = wack0_q;
  assign bus.wack1 = wack1_q;
  assign bus.werr  = werr_q;
  assign bus.wbusy = wbusy_q;
  assign bus.wgnt  = gnt_q;

endmodule

// File: tb/tb_jbus_ctrl.sv
// Self-checking bench for jbus_ctrl: default, 3-register and slow-timing instances,
// an ack scoreboard, a strobe-invariant monitor and a register-bank model.
module tb_jbus_ctrl;

  logic wclk = 1'b0;
  logic wrst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 wclk = ~wclk;

  jbus_ctrl_if #(.NREGS(4)) if_a ();
  jbus_ctrl_if #(.NREGS(3)) if_b ();
  jbus_ctrl_if #(.NREGS(4)) if_c ();

  jbus_ctrl #(.NREGS(4), .SETUP_CYC(1), .SET_CYC(2)) u_a (.wclk(wclk), .wrst_n(wrst_n), .bus(if_a.slave));
  jbus_ctrl #(.NREGS(3), .SETUP_CYC(1), .SET_CYC(2)) u_b (.wclk(wclk), .wrst_n(wrst_n), .bus(if_b.slave));
  jbus_ctrl #(.NREGS(4), .SETUP_CYC(3), .SET_CYC(1)) u_c (.wclk(wclk), .wrst_n(wrst_n), .bus(if_c.slave));

  // Scoreboard entries are {requester, werr} for instance a.
  logic [1:0] sb_q[$];
  logic [7:0] reg_m[4];

  // Register bank model: a set destination copies the enabled source.
  always @(posedge wclk) begin
    for (int d = 0; d < 4; d++)
      for (int s = 0; s < 4; s++)
        if (if_a.bws[d] && if_a.bwe[s]) reg_m[d] <= reg_m[s];
  end

  always @(negedge wclk) begin
    logic [1:0] exp_e;
    logic [1:0] got_e;
    if (wrst_n === 1'b1 && (if_a.wack0 === 1'b1 || if_a.wack1 === 1'b1)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: wack0=%0b wack1=%0b werr=%0b, required no ack", if_a.wack0, if_a.wack1, if_a.werr);
      end else begin
        exp_e = sb_q.pop_front();
        got_e = {if_a.wack1, if_a.werr};
        if (got_e !== exp_e || (if_a.wack0 && if_a.wack1)) begin
          errors++;
          $display("FAIL sb_ack: got req=%0b err=%0b (wack0=%0b), required req=%0b err=%0b",
                   got_e[1], got_e[0], if_a.wack0, exp_e[1], exp_e[0]);
        end
      end
    end
  end

  function automatic bit inv_ok(input logic [3:0] bwe, input logic [3:0] bws,
                                input logic [3:0] pbws, input int run, input int setup);
    return ($countones(bwe) <= 1) && ($countones(bws) <= 1) &&
           (bws == 4'b0 || (bwe != 4'b0 && run >= setup)) &&
           !(bwe == 4'b0 && pbws != 4'b0);
  endfunction

  int         run_a = 0, run_c = 0;
  logic [3:0] pbws_a = '0, pbws_c = '0;

  always @(negedge wclk) begin
    if (wrst_n === 1'b1) begin
      checks++;
      if (!inv_ok(if_a.bwe, if_a.bws, pbws_a, run_a, 1)) begin
        errors++;
        $display("FAIL inv_a: bwe=%b bws=%b prev_bws=%b en_run=%0d, required legal strobe sequence", if_a.bwe, if_a.bws, pbws_a, run_a);
      end
      checks++;
      if (!inv_ok(if_c.bwe, if_c.bws, pbws_c, run_c, 3)) begin
        errors++;
        $display("FAIL inv_c: bwe=%b bws=%b prev_bws=%b en_run=%0d, required legal strobe sequence", if_c.bwe, if_c.bws, pbws_c, run_c);
      end
    end
    run_a  = (if_a.bwe != 4'b0) ? run_a + 1 : 0;
    run_c  = (if_c.bwe != 4'b0) ? run_c + 1 : 0;
    pbws_a = if_a.bws;
    pbws_c = if_c.bws;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic clear_reqs();
    if_a.wreq0 = 0; if_a.wreq1 = 0; if_a.bsrc0 = '0; if_a.bdst0 = '0; if_a.bsrc1 = '0; if_a.bdst1 = '0;
    if_b.wreq0 = 0; if_b.wreq1 = 0; if_b.bsrc0 = '0; if_b.bdst0 = '0; if_b.bsrc1 = '0; if_b.bdst1 = '0;
    if_c.wreq0 = 0; if_c.wreq1 = 0; if_c.bsrc0 = '0; if_c.bdst0 = '0; if_c.bsrc1 = '0; if_c.bdst1 = '0;
  endtask

  task automatic apply_reset();
    wrst_n = 1'b0;
    clear_reqs();
    repeat (3) tick();
    wrst_n = 1'b1;
    tick();
  endtask

  task automatic drive_a(input bit req, input logic [1:0] src, input logic [1:0] dst);
    if (!req) begin if_a.wreq0 = 1; if_a.bsrc0 = src; if_a.bdst0 = dst; end
    else      begin if_a.wreq1 = 1; if_a.bsrc1 = src; if_a.bdst1 = dst; end
  endtask

  task automatic wait_ack_a(input bit req);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = req ? if_a.wack1 : if_a.wack0;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_ack%0d: no wack within 20 cycles, required one", req);
    end
  endtask

  // Single transfer on instance a, checked cycle by cycle from the sampling edge.
  task automatic xfer_a(input bit req, input logic [1:0] src, input logic [1:0] dst);
    logic [3:0] eb, es;
    drive_a(req, src, dst);
    sb_q.push_back({req, 1'b0});
    for (int k = 1; k <= 5; k++) begin
      tick();
      eb = (k <= 4) ? (4'b0001 << src) : 4'b0;
      es = (k == 2 || k == 3) ? (4'b0001 << dst) : 4'b0;
      checks++;
      if (if_a.bwe !== eb || if_a.bws !== es) begin
        errors++;
        $display("FAIL xfer_strobe c%0d: bwe=%b bws=%b, required bwe=%b bws=%b", k, if_a.bwe, if_a.bws, eb, es);
      end
    end
    checks++;
    if ((req ? if_a.wack1 : if_a.wack0) !== 1'b1 || if_a.werr !== 1'b0) begin
      errors++;
      $display("FAIL xfer_ack: wack0=%0b wack1=%0b werr=%0b in cycle 5, required wack%0d=1 werr=0",
               if_a.wack0, if_a.wack1, if_a.werr, req);
    end
    if (!req) if_a.wreq0 = 0; else if_a.wreq1 = 0;
    tick();
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    clear_reqs();
    tick(); tick();
    checks++;
    if ({if_a.bwe, if_a.bws, if_a.wack0, if_a.wack1, if_a.werr, if_a.wbusy, if_a.wgnt} !== 13'b0000_0000_00001) begin
      errors++;
      $display("FAIL reset_a: bwe=%b bws=%b ack=%0b%0b err=%0b busy=%0b gnt=%0b, required zeros and gnt=1",
               if_a.bwe, if_a.bws, if_a.wack0, if_a.wack1, if_a.werr, if_a.wbusy, if_a.wgnt);
    end
    checks++;
    if ({if_c.bwe, if_c.bws, if_c.wbusy, if_c.wgnt} !== 10'b0000_0000_01) begin
      errors++;
      $display("FAIL reset_c: bwe=%b bws=%b busy=%0b gnt=%0b, required zeros and gnt=1", if_c.bwe, if_c.bws, if_c.wbusy, if_c.wgnt);
    end
    wrst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    xfer_a(0, 2'd1, 2'd2);
    checks++;
    if (reg_m[2] !== 8'hA5) begin
      errors++;
      $display("FAIL basic_copy: reg2=%h, required a5", reg_m[2]);
    end
    checks++;
    if (if_a.wgnt !== 1'b0 || if_a.wbusy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: wgnt=%0b wbusy=%0b, required 0 0", if_a.wgnt, if_a.wbusy);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    drive_a(0, 2'd0, 2'd3);
    drive_a(1, 2'd2, 2'd1);
    sb_q.push_back(2'b00);
    sb_q.push_back(2'b10);
    wait_ack_a(0);
    if_a.wreq0 = 0;
    wait_ack_a(1);
    if_a.wreq1 = 0;
    tick();
    checks++;
    if (if_a.wgnt !== 1'b1) begin
      errors++;
      $display("FAIL rr_gnt1: wgnt=%0b, required 1", if_a.wgnt);
    end
    drive_a(0, 2'd0, 2'd3);
    drive_a(1, 2'd2, 2'd1);
    sb_q.push_back(2'b00);
    wait_ack_a(0);
    if_a.wreq0 = 0;
    if_a.wreq1 = 0;
    tick(); tick();
    checks++;
    if (if_a.wbusy !== 1'b0 || if_a.wgnt !== 1'b0) begin
      errors++;
      $display("FAIL rr_third: wbusy=%0b wgnt=%0b, required 0 0", if_a.wbusy, if_a.wgnt);
    end
  endtask

  task automatic test_bad_req();
    drive_a(1, 2'd3, 2'd3);
    sb_q.push_back(2'b11);
    tick();
    checks++;
    if ({if_a.wack1, if_a.werr, if_a.bwe, if_a.bws, if_a.wbusy} !== 11'b11_0000_0000_1) begin
      errors++;
      $display("FAIL bad_a: wack1=%0b werr=%0b bwe=%b bws=%b busy=%0b, required 1 1 0000 0000 1",
               if_a.wack1, if_a.werr, if_a.bwe, if_a.bws, if_a.wbusy);
    end
    if_a.wreq1 = 0;
    tick();
    checks++;
    if (if_a.wbusy !== 1'b0 || if_a.wack1 !== 1'b0) begin
      errors++;
      $display("FAIL bad_a_idle: wbusy=%0b wack1=%0b, required 0 0", if_a.wbusy, if_a.wack1);
    end
    if_b.wreq1 = 1; if_b.bsrc1 = 2'd3; if_b.bdst1 = 2'd0;
    tick();
    checks++;
    if ({if_b.wack1, if_b.wack0, if_b.werr, if_b.bwe, if_b.bws} !== 9'b101_000_000) begin
      errors++;
      $display("FAIL bad_b: wack1=%0b wack0=%0b werr=%0b bwe=%b bws=%b, required 1 0 1 000 000",
               if_b.wack1, if_b.wack0, if_b.werr, if_b.bwe, if_b.bws);
    end
    if_b.wreq1 = 0;
    tick();
  endtask

  task automatic test_slow_timing();
    logic [3:0] eb, es;
    if_c.wreq0 = 1; if_c.bsrc0 = 2'd0; if_c.bdst0 = 2'd3;
    for (int k = 1; k <= 6; k++) begin
      tick();
      eb = (k <= 5) ? 4'b0001 : 4'b0000;
      es = (k == 4) ? 4'b1000 : 4'b0000;
      checks++;
      if (if_c.bwe !== eb || if_c.bws !== es || if_c.wack0 !== (k == 6)) begin
        errors++;
        $display("FAIL slow c%0d: bwe=%b bws=%b wack0=%0b, required bwe=%b bws=%b wack0=%0b",
                 k, if_c.bwe, if_c.bws, if_c.wack0, eb, es, (k == 6));
      end
    end
    if_c.wreq0 = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    drive_a(0, 2'd2, 2'd0);
    tick(); tick();
    checks++;
    if (if_a.bws !== 4'b0001) begin
      errors++;
      $display("FAIL mid_set: bws=%b, required 0001", if_a.bws);
    end
    wrst_n = 1'b0;
    tick();
    checks++;
    if ({if_a.bwe, if_a.bws, if_a.wbusy, if_a.wack0} !== 10'b0) begin
      errors++;
      $display("FAIL mid_abort: bwe=%b bws=%b busy=%0b wack0=%0b, required all 0", if_a.bwe, if_a.bws, if_a.wbusy, if_a.wack0);
    end
    if_a.wreq0 = 0;
    tick();
    wrst_n = 1'b1;
    repeat (3) tick();
    xfer_a(0, 2'd2, 2'd0);
  endtask

  task automatic test_drop();
    drive_a(0, 2'd1, 2'd3);
    sb_q.push_back(2'b00);
    sb_q.push_back(2'b10);
    tick();
    if_a.wreq0 = 0;
    drive_a(1, 2'd3, 2'd0);
    wait_ack_a(0);
    wait_ack_a(1);
    if_a.wreq1 = 0;
    tick();
    checks++;
    if (reg_m[3] !== 8'hA5) begin
      errors++;
      $display("FAIL drop_copy: reg3=%h, required a5", reg_m[3]);
    end
  endtask

  initial begin
    reg_m[0] = 8'h3C; reg_m[1] = 8'hA5; reg_m[2] = 8'h00; reg_m[3] = 8'hF0;
    wrst_n = 1'b0;
    clear_reqs();
    test_reset();
    test_basic();
    test_round_robin();
    test_bad_req();
    test_slow_timing();
    test_reset_mid();
    test_drop();
    repeat (3) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d acks outstanding, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jbus_ctrl.md
Name: jbus_ctrl

Overview:
Sequencer and arbiter for a bank of NREGS 8-bit bus registers that share one internal bus. Each register has a set strobe (ws) and an enable strobe (we). Two requesters ask for register-to-register transfers (src -> dst). The block grants one requester at a time by round-robin, then drives the enable/set strobe sequence the latch-based registers need: enable the source, pulse set on the destination while the source is still enabled, hold, then release.

Parameters:
NREGS, 4, number of registers on the shared bus (2..16).
SETUP_CYC, 1, cycles the source enable is high before the destination set rises (1..15).
SET_CYC, 2, cycles the destination set stays high (1..15; covers the latch update delay).
IDXW, $clog2(NREGS), width of the register index; derived, do not override.

Ports:
wclk  in  1  clock; all state changes on the rising edge
wrst_n  in  1  reset, synchronous, active-low
wreq0  in  1  requester 0 transfer request
bsrc0  in  IDXW  requester 0 source register index
bdst0  in  IDXW  requester 0 destination register index
wreq1  in  1  requester 1 transfer request
bsrc1  in  IDXW  requester 1 source register index
bdst1  in  IDXW  requester 1 destination register index
wack0  out  1  one-cycle completion pulse to requester 0
wack1  out  1  one-cycle completion pulse to requester 1
werr  out  1  high together with wack when the transfer was rejected
bwe  out  NREGS  one-hot register enable strobes
bws  out  NREGS  one-hot register set strobes
wbusy  out  1  high in every state except IDLE
wgnt  out  1  index of the current or most recent grant

Behaviour:
- Clock and reset: one clock, wclk. Reset is synchronous and active-low on wrst_n.
- Registered outputs: every output comes from a register.
- Reset values: bwe=0, bws=0, wack0=wack1=werr=0, wbusy=0, wgnt=1, state=IDLE. wgnt=1 means requester 0 wins the first contention.
- States: IDLE, EN, SET, HOLD, DONE.
- IDLE:
  - Sample wreq0 and wreq1.
  - With one request, grant it. With both, grant the requester that is not wgnt (round-robin).
  - On a grant, latch that requester's src/dst indices and set wgnt to it.
  - Bad request (src==dst, src>=NREGS or dst>=NREGS): go directly to DONE with werr=1. No strobe toggles.
  - Good request: go to EN.
- EN: bwe[src]=1 for SETUP_CYC cycles, then go to SET.
- SET: bwe[src]=1 and bws[dst]=1 for SET_CYC cycles, then go to HOLD.
- HOLD: bws=0 and bwe[src]=1 for one cycle, so the bus stays stable while set falls. Then go to DONE.
- DONE: bwe=0, bws=0. Pulse wack of the granted requester for one cycle (werr as determined in IDLE). Then go to IDLE.
- Latency: wreq sampled at edge N gives wack high in cycle N+SETUP_CYC+SET_CYC+2. With defaults this is ack in the 5th cycle after the sampling edge.
- Handshake:
  - A requester holds wreq, bsrc and bdst stable until it sees wack.
  - The requester must drive wreq low in the cycle after wack. Otherwise IDLE treats the held wreq as a new request.
  - If wreq drops mid-transfer, the transfer still completes and wack still pulses.
- Strobe invariants:
  - At most one bit of bwe is high, and at most one bit of bws is high.
  - bws is never high unless bwe has been high for at least SETUP_CYC cycles.
  - bws falls at least one cycle before bwe.
- Phase counter: 4 bits, loaded on state entry, decremented each cycle; leave the state at terminal count.
- Reset mid-transfer: on the next edge all strobes and acks go to 0 and the state returns to IDLE. No ack is issued for the aborted transfer.

Decomposition:
- Package jbus_pkg holds:
  - the state enum (IDLE, EN, SET, HOLD, DONE);
  - the phase-counter width constant (4);
  - a function idx_ok(src, dst, nregs) for the validity check.
- Sub-module jrr_arb2: two-input round-robin arbiter.
  - Inputs: wreq0, wreq1, last-grant pointer.
  - Outputs: wvalid, wgnt.
  - Purely combinational. The pointer register lives in jbus_ctrl.

Test Plan:
1. Reset, then wreq0 with src=1, dst=2 (defaults) -> bwe=0010 for cycle 1; bwe=0010 and bws=0100 for cycles 2-3; bwe=0010 and bws=0 in cycle 4; wack0=1, werr=0 in cycle 5. A jlregister bank model shows reg2 equal to reg1 (e.g. 8'hA5).
2. wreq0 and wreq1 asserted together right after reset, both held -> requester 0 served first, then requester 1. Then assert both again -> requester 0 served. wack pulses alternate 0,1,0.
3. wreq1 with src=3, dst=3 -> DONE in 1 cycle, wack1=1 and werr=1, bwe and bws stay 0. Repeat with NREGS=3 and src=3 -> same error response.
4. SETUP_CYC=3, SET_CYC=1 -> bwe alone for 3 cycles, bws for 1 cycle, ack in cycle 6. A strobe-invariant assertion holds throughout.
5. wrst_n=0 during SET -> next edge bwe=bws=0, wbusy=0, no wack. After release, a new wreq0 completes normally.
6. wreq0 dropped during EN -> transfer completes and wack0 pulses. Requester 1 held high is granted in the following IDLE.
